// File: rtl/seg7_scan_60_display.sv
// Two-digit multiplexed 7-segment driver for a 0-59 BCD seconds counter.
// Captures both digits once per scan frame so the displayed pair never tears.
module seg7_scan_60_display #(
    parameter int CLK_DIV    = 50000,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] q0,
    input  logic [2:0] q1,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int             CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [6:0]     SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]     AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [CW-1:0] r_cnt;
    logic          r_sel;
    logic [3:0]    r_s0;
    logic [2:0]    r_s1;
    logic          r_err;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    logic          w_tick;
    logic          w_capture;
    logic          w_bad;
    logic [6:0]    w_seg_raw;
    logic [1:0]    w_an_raw;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign w_tick    = en && (r_cnt == CNT_MAX);
    // The frame ends on the tens->ones tick; that is where both digits are sampled.
    assign w_capture = w_tick && r_sel;
    assign w_bad     = (q0 > 4'd9) || (q1 > 3'd5);

    // NOTE: every output is assigned a default first so no latch is inferred.
    always_comb begin
        w_seg_raw = 7'h00;
        w_an_raw  = 2'b00;
        if (en) begin
            if (!r_sel) begin
                w_seg_raw = decode(r_s0);
                w_an_raw  = 2'b01;
            end else if (!(BLANK_LZ && (r_s1 == 3'd0))) begin
                w_seg_raw = (r_s1 > 3'd5) ? 7'h40 : decode({1'b0, r_s1});
                w_an_raw  = 2'b10;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
            r_s0  <= 4'd0;
            r_s1  <= 3'd0;
            r_err <= 1'b0;
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            if (!en) begin
                r_cnt <= '0;
                r_sel <= 1'b0;
            end else if (w_tick) begin
                r_cnt <= '0;
                r_sel <= ~r_sel;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_capture) begin
                r_s0 <= q0;
                r_s1 <= q1;
                if (w_bad) begin
                    r_err <= 1'b1;
                end
            end

            r_seg <= ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
            r_an  <= ACTIVE_LOW ? ~w_an_raw  : w_an_raw;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign err = r_err;

endmodule

// File: tb/tb_seg7_scan_60_display.sv
// Randomized bench for seg7_scan_60_display: two instances (active-low with blanking,
// active-high without) compared each cycle against a frame-position reference model.
module tb_seg7_scan_60_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] q0 = 4'd0;
    logic [2:0] q1 = 3'd0;

    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a, an_b;
    logic       err_a, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: edges since the scan restarted, captured digits, sticky error.
    int m_k  = 0;
    int m_d0 = 0;
    int m_d1 = 0;
    bit m_err = 1'b0;
    logic [6:0] e_seg_a, e_seg_b;
    logic [1:0] e_an_a, e_an_b;

    logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_scan_60_display #(.CLK_DIV(DIV), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .q0(q0), .q1(q1),
        .seg(seg_a), .an(an_a), .err(err_a)
    );

    seg7_scan_60_display #(.CLK_DIV(DIV), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .q0(q0), .q1(q1),
        .seg(seg_b), .an(an_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] m_seg(bit al, bit bl, bit on, int slot, int d0, int d1);
        logic [6:0] v;
        v = 7'h00;
        if (on) begin
            if (slot == 0) v = (d0 <= 9) ? lut[d0] : 7'h40;
            else if (!(bl && d1 == 0)) v = (d1 <= 5) ? lut[d1] : 7'h40;
        end
        return al ? ~v : v;
    endfunction

    function automatic logic [1:0] m_an(bit al, bit bl, bit on, int slot, int d1);
        logic [1:0] v;
        v = 2'b00;
        if (on) begin
            if (slot == 0) v = 2'b01;
            else if (!(bl && d1 == 0)) v = 2'b10;
        end
        return al ? ~v : v;
    endfunction

    task automatic step(input bit rst_v, input bit en_v, input int q0_v, input int q1_v);
        int slot;
        @(negedge clk);
        rst_n = rst_v;
        en    = en_v;
        q0    = 4'(q0_v);
        q1    = 3'(q1_v);
        @(posedge clk);
        if (!rst_v) begin
            e_seg_a = 7'h7F; e_an_a = 2'b11;
            e_seg_b = 7'h00; e_an_b = 2'b00;
            m_k = 0; m_d0 = 0; m_d1 = 0; m_err = 1'b0;
        end else begin
            slot    = (m_k / DIV) % 2;
            e_seg_a = m_seg(1'b1, 1'b1, en_v, slot, m_d0, m_d1);
            e_an_a  = m_an (1'b1, 1'b1, en_v, slot, m_d1);
            e_seg_b = m_seg(1'b0, 1'b0, en_v, slot, m_d0, m_d1);
            e_an_b  = m_an (1'b0, 1'b0, en_v, slot, m_d1);
            if (!en_v) begin
                m_k = 0;
            end else begin
                m_k++;
                if (m_k % (2 * DIV) == 0) begin
                    m_d0 = q0_v;
                    m_d1 = q1_v;
                    if (q0_v > 9 || q1_v > 5) m_err = 1'b1;
                end
            end
        end
        #1;
        check("seg_a", {1'b0, seg_a}, {1'b0, e_seg_a});
        check("an_a",  {6'd0, an_a},  {6'd0, e_an_a});
        check("err_a", {7'd0, err_a}, {7'd0, m_err});
        check("seg_b", {1'b0, seg_b}, {1'b0, e_seg_b});
        check("an_b",  {6'd0, an_b},  {6'd0, e_an_b});
        check("err_b", {7'd0, err_b}, {7'd0, m_err});
    endtask

    initial begin
        bit en_r;
        int q0_r, q1_r;

        repeat (3) step(1'b0, 1'b1, 0, 0);
        repeat (20) step(1'b1, 1'b1, 0, 0);
        repeat (24) step(1'b1, 1'b1, 7, 3);
        repeat (6)  step(1'b1, 1'b1, 8, 3);
        repeat (16) step(1'b1, 1'b1, 8, 3);
        repeat (16) step(1'b1, 1'b1, 12, 3);
        repeat (20) step(1'b1, 1'b1, 5, 3);
        repeat (6)  step(1'b1, 1'b0, 5, 3);
        repeat (20) step(1'b1, 1'b1, 5, 3);
        repeat (2)  step(1'b0, 1'b1, 5, 3);
        repeat (12) step(1'b1, 1'b1, 9, 5);

        en_r = 1'b1; q0_r = 9; q1_r = 5;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) en_r = ~en_r;
            if ($urandom_range(0, 7) == 0)
                q0_r = ($urandom_range(0, 99) < 3) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0)
                q1_r = ($urandom_range(0, 99) < 3) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            step(($urandom_range(0, 199) != 0), en_r, q0_r, q1_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
